// File: rtl/i2c_arb_pkg.sv
// rtl/i2c_arb_pkg.sv - shared types and widths for the I2C bus arbiter
package i2c_arb_pkg;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_FINISH
    } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin select starting at ptr
module rr_picker #(
    parameter int N_REQ = 2,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant_onehot,
    output logic [IDX_W-1:0] grant_idx
);

    logic             found;
    logic [IDX_W-1:0] idx;

    // Walk the requesters in order ptr, ptr+1, ... and keep the first one set.
    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        found        = 1'b0;
        idx          = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = IDX_W'((int'(ptr) + k) % N_REQ);
            if (!found && req[idx]) begin
                found             = 1'b1;
                grant_onehot[idx] = 1'b1;
                grant_idx         = idx;
            end
        end
    end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// rtl/i2c_bus_arbiter.sv - round-robin sharing of one byte-level I2C master with watchdog
module i2c_bus_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int N_REQ          = 2,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [ADDR_W*N_REQ-1:0] dev_addr,
    input  logic [N_REQ-1:0]        rw,
    input  logic [DATA_W*N_REQ-1:0] wdata,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        done,
    output logic [DATA_W-1:0]       rdata,
    output logic                    nack,
    output logic                    timeout,
    output logic                    m_start,
    output logic                    m_abort,
    output logic [ADDR_W-1:0]       m_addr,
    output logic                    m_rw,
    output logic [DATA_W-1:0]       m_wdata,
    input  logic                    m_done,
    input  logic [DATA_W-1:0]       m_rdata,
    input  logic                    m_nack
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    arb_state_e        state_q, state_d;
    logic [IDX_W-1:0]  ptr_q;
    logic [IDX_W-1:0]  owner_q;
    logic [WD_W-1:0]   wd_cnt;
    logic              to_flag;
    logic              wd_expired;
    logic [N_REQ-1:0]  pick_onehot;
    logic [IDX_W-1:0]  pick_idx;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_rw;
    logic [DATA_W-1:0] sel_wdata;

    rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req          (req),
        .ptr          (ptr_q),
        .grant_onehot (pick_onehot),
        .grant_idx    (pick_idx)
    );

    always_comb begin
        sel_addr  = '0;
        sel_rw    = 1'b0;
        sel_wdata = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_onehot[i]) begin
                sel_addr  = dev_addr[i*ADDR_W +: ADDR_W];
                sel_rw    = rw[i];
                sel_wdata = wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign wd_expired = (wd_cnt == WD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // m_done has priority over the watchdog when both land in the same WAIT cycle.
    always_comb begin
        state_d = state_q;
        m_start = 1'b0;
        m_abort = 1'b0;
        done    = '0;
        timeout = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|req) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                m_start = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (m_done) begin
                    state_d = ST_FINISH;
                end else if (wd_expired) begin
                    m_abort = 1'b1;
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                done    = gnt;
                timeout = to_flag;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt     <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            m_addr  <= '0;
            m_rw    <= 1'b0;
            m_wdata <= '0;
            wd_cnt  <= '0;
            to_flag <= 1'b0;
            rdata   <= '0;
            nack    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|req) begin
                        gnt     <= pick_onehot;
                        owner_q <= pick_idx;
                        m_addr  <= sel_addr;
                        m_rw    <= sel_rw;
                        m_wdata <= sel_wdata;
                        to_flag <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    wd_cnt <= '0;
                end
                ST_WAIT: begin
                    if (m_done) begin
                        rdata <= m_rdata;
                        nack  <= m_nack;
                    end else if (wd_expired) begin
                        rdata   <= '0;
                        nack    <= 1'b1;
                        to_flag <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                ST_FINISH: begin
                    gnt   <= '0;
                    ptr_q <= (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// tb/tb_i2c_bus_arbiter.sv - randomized self-checking bench for i2c_bus_arbiter
module tb_i2c_bus_arbiter;

    localparam int N  = 3;
    localparam int TO = 16;
    localparam int AW = 7 * N;
    localparam int DW = 8 * N;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req;
    logic [AW-1:0] dev_addr;
    logic [N-1:0]  rw;
    logic [DW-1:0] wdata;
    logic [N-1:0]  gnt;
    logic [N-1:0]  done;
    logic [7:0]    rdata;
    logic          nack;
    logic          timeout;
    logic          m_start;
    logic          m_abort;
    logic [6:0]    m_addr;
    logic          m_rw;
    logic [7:0]    m_wdata;
    logic          m_done;
    logic [7:0]    m_rdata;
    logic          m_nack;

    always #5 clk = ~clk;

    i2c_bus_arbiter #(
        .N_REQ          (N),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .dev_addr (dev_addr),
        .rw       (rw),
        .wdata    (wdata),
        .gnt      (gnt),
        .done     (done),
        .rdata    (rdata),
        .nack     (nack),
        .timeout  (timeout),
        .m_start  (m_start),
        .m_abort  (m_abort),
        .m_addr   (m_addr),
        .m_rw     (m_rw),
        .m_wdata  (m_wdata),
        .m_done   (m_done),
        .m_rdata  (m_rdata),
        .m_nack   (m_nack)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Transaction-level model: each grant is turned into a schedule of
    // absolute cycle numbers (issue, abort, done) plus the expected results.
    bit           rst_cmd  = 1'b0;
    int           req_mode = 1;
    logic [N-1:0] req_hold = '0;
    int           force_k  = -1;
    bit           busy     = 1'b0;
    int           t_issue  = 0;
    int           t_done   = 0;
    int           k_plan   = 0;
    int           ptr_m    = 0;
    int           owner_m  = 0;
    logic [6:0]   exp_addr;
    logic         exp_rw;
    logic [7:0]   exp_wdata;
    logic [7:0]   exp_rdata;
    logic         exp_nack;
    logic         exp_to;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int pick_winner(input logic [N-1:0] r, input int p);
        logic [N-1:0] s;
        for (int j = 0; j < N; j++) begin
            s = r >> ((p + j) % N);
            if (s[0]) return (p + j) % N;
        end
        return 0;
    endfunction

    task automatic step();
        logic [N-1:0]  sh;
        logic [N-1:0]  oh;
        logic [AW-1:0] ta;
        logic [DW-1:0] tw;
        int            k;
        int            r;
        @(posedge clk);
        #1;
        cyc++;
        rst_n = rst_cmd;
        if (busy && cyc > t_done) busy = 1'b0;
        if (!rst_cmd) begin
            busy  = 1'b0;
            ptr_m = 0;
        end
        if (req_mode == 0) begin
            req      = req ^ N'($urandom & $urandom);
            rw       = N'($urandom);
            dev_addr = AW'($urandom);
            wdata    = DW'($urandom);
        end else begin
            req = req_hold;
        end
        m_rdata = 8'($urandom);
        m_nack  = 1'($urandom);
        m_done  = 1'b0;
        if (busy && k_plan > 0 && cyc == t_issue + k_plan) begin
            m_done = 1'b1;
            if (k_plan <= TO) begin
                exp_rdata = m_rdata;
                exp_nack  = m_nack;
            end
        end else if (!busy || cyc <= t_issue || cyc >= t_done) begin
            m_done = ($urandom_range(0, 7) == 0);
        end
        if (rst_cmd && !busy && req != '0) begin
            owner_m   = pick_winner(req, ptr_m);
            ptr_m     = (owner_m + 1) % N;
            ta        = dev_addr >> (7 * owner_m);
            exp_addr  = ta[6:0];
            tw        = wdata >> (8 * owner_m);
            exp_wdata = tw[7:0];
            sh        = rw >> owner_m;
            exp_rw    = sh[0];
            if (force_k >= 0) begin
                k = force_k;
            end else begin
                r = $urandom_range(0, 19);
                if (r < 12)      k = $urandom_range(1, 12);
                else if (r < 15) k = TO;
                else if (r < 17) k = TO + 1;
                else             k = 0;
            end
            k_plan  = k;
            t_issue = cyc + 1;
            exp_to  = !(k >= 1 && k <= TO);
            t_done  = exp_to ? t_issue + TO + 1 : t_issue + k + 1;
            if (exp_to) begin
                exp_rdata = 8'h00;
                exp_nack  = 1'b1;
            end
            busy = 1'b1;
        end
        @(negedge clk);
        if (!rst_cmd) begin
            check_eq("reset_outputs",
                     {gnt, done, rdata, nack, timeout, m_start, m_abort, m_addr, m_rw, m_wdata},
                     64'd0);
        end else begin
            oh = (busy && cyc >= t_issue && cyc <= t_done) ? (N'(1) << owner_m) : '0;
            check_eq("gnt", gnt, oh);
            check_eq("m_start", m_start, busy && cyc == t_issue);
            check_eq("m_abort", m_abort, busy && exp_to && cyc == t_issue + TO);
            if (busy && cyc == t_done) begin
                check_eq("done", done, N'(1) << owner_m);
                check_eq("rdata", rdata, exp_rdata);
                check_eq("nack", nack, exp_nack);
                check_eq("timeout", timeout, exp_to);
            end else begin
                check_eq("done_idle", done, '0);
                check_eq("timeout_idle", timeout, 1'b0);
            end
            if (busy && cyc == t_issue) begin
                check_eq("m_addr", m_addr, exp_addr);
                check_eq("m_rw", m_rw, exp_rw);
                check_eq("m_wdata", m_wdata, exp_wdata);
            end
        end
    endtask

    task automatic one_shot(input logic [N-1:0] r, input int k, input int tail);
        req_hold = r;
        force_k  = k;
        step();
        req_hold = '0;
        repeat (tail) step();
    endtask

    initial begin
        rst_n    = 1'b0;
        req      = '0;
        dev_addr = '0;
        rw       = '0;
        wdata    = '0;
        m_done   = 1'b0;
        m_rdata  = '0;
        m_nack   = 1'b0;

        repeat (3) step();
        rst_cmd = 1'b1;

        // single write, master answers 10 cycles after m_start
        dev_addr[6:0] = 7'h52;
        wdata[7:0]    = 8'hA5;
        one_shot(3'b001, 10, 16);

        // read from requester 1
        dev_addr[13:7] = 7'h52;
        rw[1]          = 1'b1;
        one_shot(3'b010, 5, 10);

        // watchdog expiry, m_done on the expiry cycle, m_done just too late
        one_shot(3'b001, 0, 22);
        one_shot(3'b100, TO, 22);
        one_shot(3'b010, TO + 1, 22);

        // two requesters held high
        req_hold = 3'b011;
        force_k  = -1;
        repeat (80) step();
        req_hold = '0;
        repeat (20) step();

        req_mode = 0;
        repeat (1500) step();

        // reset while the owner is waiting on the master
        req_mode = 1;
        req_hold = 3'b100;
        force_k  = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (busy && cyc >= t_issue + 4) break;
        end
        rst_cmd = 1'b0;
        repeat (2) step();
        rst_cmd  = 1'b1;
        req_hold = 3'b111;
        force_k  = 3;
        repeat (40) step();

        req_mode = 0;
        force_k  = -1;
        repeat (500) step();
        req_mode = 1;
        req_hold = '0;
        repeat (25) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/i2c_bus_arbiter.md
# i2c_bus_arbiter

Round-robin arbiter sharing one byte-level I2C master engine (the block driving `scl`/`sda`) between several requesters, e.g. the NES controller poller and the CPU MMIO port. It accepts whole single-byte transactions from each requester, serialises them onto the master, returns read data and NACK status, and recovers from a hung bus with a watchdog. It sits between the requesters and the I2C master inside the NES bridge top level.

## Interface
Parameters:
- `N_REQ`, 2: number of requesters (2..8).
- `TIMEOUT_CYCLES`, 1_000_000: watchdog limit, in clk cycles, on one master transaction.

Ports:
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req`  in  N_REQ  per-requester request level, held until its `done` pulse.
- `dev_addr`  in  7*N_REQ  7-bit device address, slice i belongs to requester i.
- `rw`  in  N_REQ  1 = read, 0 = write.
- `wdata`  in  8*N_REQ  write byte.
- `gnt`  out  N_REQ  one-hot owner of the master; zero when idle.
- `done`  out  N_REQ  one-cycle completion pulse to the owner.
- `rdata`  out  8  read byte, valid in the `done` cycle.
- `nack`  out  1  error flag, valid in the `done` cycle (device NACK or timeout).
- `timeout`  out  1  one-cycle pulse in the `done` cycle when the watchdog fired.
- `m_start`  out  1  one-cycle command strobe to the master.
- `m_abort`  out  1  one-cycle strobe: master must release the bus and return idle.
- `m_addr`  out  7  latched address.
- `m_rw`  out  1  latched direction.
- `m_wdata`  out  8  latched write byte.
- `m_done`  in  1  master completion pulse.
- `m_rdata`  in  8  master read byte, valid with `m_done`.
- `m_nack`  in  1  master NACK flag, valid with `m_done`.

## Operation
- FSM states: IDLE, ISSUE, WAIT, FINISH.
- IDLE: if any `req` is high, pick winner by round-robin starting at pointer `ptr`; latch its `dev_addr`/`rw`/`wdata` into `m_*`; set `gnt` one-hot; go to ISSUE.
- ISSUE: `m_start`=1 for exactly this cycle; clear watchdog; go to WAIT.
- WAIT: on `m_done`, latch `m_rdata`→`rdata` and `m_nack`→`nack`; go to FINISH. If the watchdog reaches `TIMEOUT_CYCLES`-1 first: `m_abort`=1 for one cycle, `nack`=1, `rdata`=0, set the timeout flag; go to FINISH.
- FINISH: `done[owner]`=1 for one cycle, `timeout` pulsed if flagged, `gnt` cleared at the end of the cycle, `ptr` ← owner+1 mod N_REQ; go to IDLE.
- The owner dropping `req` mid-transaction is ignored. The transaction completes and `done` still pulses.
- `req` from non-owners during a transaction is held off and not queued beyond the level itself.
- Round-robin: owner i gets lowest priority next arbitration. With all requests high, grants rotate 0,1,…,N_REQ-1,0.
- `m_done` arriving in a cycle other than WAIT is ignored.
- `m_done` and the watchdog expiry in the same cycle: `m_done` wins, no timeout.
- Reset value of every output is 0: `gnt`, `done`, `rdata`, `nack`, `timeout`, `m_start`, `m_abort`, `m_addr`, `m_rw`, `m_wdata`. `ptr`=0, state IDLE.
- Reset asserted mid-transaction returns to IDLE immediately. No `done` and no `m_abort` are issued, because the master is reset by the same `rst_n`.

## Timing
- `req` high, sampled in IDLE at edge N: `gnt` and `m_*` valid after edge N; `m_start` high during cycle N+1 (ISSUE).
- `m_done` sampled at edge M: `done`/`rdata`/`nack` high during cycle M+1; `gnt` low after edge M+1.
- Earliest next grant is sampled at edge M+2. Arbitration overhead is 3 cycles per transaction beyond master latency.
- A requester that keeps `req` high through the `done` cycle is treated as a new request at the next IDLE.
- Watchdog: counter width is clog2(`TIMEOUT_CYCLES`). It counts WAIT cycles only and expires on the WAIT cycle where count = `TIMEOUT_CYCLES`-1.

## Structure
- Package `i2c_arb_pkg`: state enum, `ADDR_W`=7, `DATA_W`=8.
- Sub-module `rr_picker`: combinational one-hot round-robin select from (`req`, `ptr`); outputs `grant_onehot`, `grant_idx`.
- Arbiter top contains the FSM, command latches, watchdog counter and pointer register.

## Test plan
- Single write: req[0]=1, addr 0x52, rw=0, wdata 0xA5; master `m_done` 10 cycles after `m_start` → `m_addr`=0x52, `m_wdata`=0xA5, one `m_start`, `done[0]` one cycle, `nack`=0, `gnt`=0 afterwards.
- Contention: req[0] and req[1] held high for 4 transactions → grant order 0,1,0,1; exactly 4 `m_start` pulses, never two `gnt` bits high.
- Read return: req[1] read from 0x52, master returns `m_rdata`=0x3C → `rdata`=0x3C, `nack`=0 in `done[1]` cycle.
- NACK and timeout: master returns `m_nack`=1 → `nack`=1, `timeout`=0. With `TIMEOUT_CYCLES`=16 and no `m_done` → `m_abort` after 16 WAIT cycles, then `done`+`nack`+`timeout`=1.
- Boundary events: `m_done` on the expiry cycle → no timeout, `nack`=`m_nack`. `req` dropped mid-WAIT → `done` still pulses.
- Reset mid-transaction: `rst_n`=0 during WAIT → all outputs 0 immediately. After release, no `done` pulses and a fresh request is granted to requester 0 first.
